ahb_mem_slave: RTL and testbench
================================

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AHB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, memory size in DATA_WIDTH words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15, extra data-phase cycles per OKAY transfer.
REQ-005 SHALL have port hclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port hresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port hsel, input, 1 bit: slave select.
REQ-008 SHALL have port haddr, input, ADDR_WIDTH bits: byte address.
REQ-009 SHALL have port hsize, input, 3 bits: transfer size.
REQ-010 SHALL have port htrans, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-012 SHALL have port hwdata, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port hready_in, input, 1 bit: bus-level ready.
REQ-014 SHALL have port hburst, input, 3 bits: ignored; transfers are handled individually.
REQ-015 SHALL have port hrdata, output, DATA_WIDTH bits: read data.
REQ-016 SHALL have port hready, output, 1 bit: transfer done.
REQ-017 SHALL have port hresp, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-018 SHALL accept an address phase at a rising edge only when hsel=1, hready_in=1 and htrans[1]=1; IDLE and BUSY transfers are not accepted and get a zero-wait OKAY.
REQ-019 SHALL register haddr, hsize and hwrite on acceptance and SHALL leave them unchanged until the data phase completes.
REQ-020 SHALL flag an accepted transfer as ERROR when:
- haddr >= MEM_DEPTH*4, or
- hsize > 2, or
- haddr is misaligned to hsize.
REQ-021 SHALL use the FSM states IDLE, WAIT, ERR1 and ERR2.
REQ-022 SHALL make these FSM transitions:
- IDLE to WAIT on a valid accept when WAIT_STATES > 0.
- IDLE to ERR1 on an error accept.
- WAIT to IDLE after WAIT_STATES cycles.
- ERR1 to ERR2.
- ERR2 to IDLE, or to WAIT/ERR1 if a new transfer is accepted in ERR2.
REQ-023 SHALL drive hready=0, hresp=0 in WAIT; hready=0, hresp=1 in ERR1; hready=1, hresp=1 in ERR2.
REQ-024 SHALL complete an OKAY transfer with hready=1, hresp=0 in the cycle after the final wait cycle, or immediately when WAIT_STATES=0.
REQ-025 SHALL, on reads, drive the full addressed word on hrdata in the completing cycle; byte-lane selection is the master's job.
REQ-026 SHALL drive hrdata to 0 in cycles that do not complete a read.
REQ-027 SHALL, on writes, sample hwdata in the completing cycle and update only the byte lanes given by hsize and haddr[1:0], little-endian.
REQ-028 SHALL NOT modify memory on an ERROR transfer.
REQ-029 SHALL, when an OKAY write and a new read of the same word are accepted back to back, return the newly written data for the read.
REQ-030 SHALL accept a new address phase in the completing cycle of the previous transfer (pipelined, no bubble).
REQ-031 SHALL use a wait counter of 4 bits; with WAIT_STATES=15 there are exactly 15 hready-low cycles.

Reset
REQ-032 SHALL, on hresetn=0, asynchronously force state=IDLE, hready=1, hresp=0, hrdata=0 and the wait counter to 0.
REQ-033 SHALL, on reset during WAIT/ERR1/ERR2, abort the transfer with no memory write.
REQ-034 SHALL NOT reset memory contents; they are undefined until written.

Verification
REQ-035 SHALL cover: WAIT_STATES=0, write word 0xDEADBEEF at 0x10, then read 0x10 -> OKAY, zero wait, hrdata=0xDEADBEEF.
REQ-036 SHALL cover: WAIT_STATES=3, read -> exactly 3 cycles of hready=0, then hready=1, hresp=0.
REQ-037 SHALL cover: byte write 0xAA at 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344.
REQ-038 SHALL cover: read at MEM_DEPTH*4, halfword at 0x01, and hsize=3 -> each gives ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); memory unchanged.
REQ-039 SHALL cover: hsel=1 with htrans=IDLE or BUSY -> no accept, hready=1, hresp=0, memory unchanged.
REQ-040 SHALL cover: hresetn asserted mid-WAIT of a write -> hready=1, hresp=0 immediately; later read shows old data.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-Lite memory slave with configurable wait states and error responses
//
// Purpose: word-organised memory (MEM_DEPTH x 32-bit) behind an AHB-Lite
// slave port. Byte/halfword/word writes update only the addressed lanes;
// reads return the full word. Out-of-range, oversize or misaligned
// transfers get a two-cycle ERROR response and never touch memory.
//
// Ports:
//   hclk, hresetn        clock (rising edge), asynchronous active-low reset
//   hsel, hready_in      slave select, bus-level ready
//   haddr, hsize, htrans address-phase controls (htrans[1]=1 means NONSEQ/SEQ)
//   hwrite, hburst       direction; burst type (unused, transfers are independent)
//   hwdata               write data, sampled in the completing data-phase cycle
//   hrdata               read data, zero except in a completing read cycle
//   hready, hresp        transfer done, 0=OKAY / 1=ERROR
module ahb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  input  logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp
);

  localparam int                  IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT     = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
  localparam logic [3:0]          LAST_WAIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2:0]              r_size;
  logic                    r_write;
  logic                    r_pend;     // an accepted OKAY transfer is in its data phase
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_accept;
  logic                    w_misalign;
  logic                    w_err;
  logic                    w_complete;
  logic [3:0]              w_strb;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_unused;

  // hready is a function of state only, so using it here forms no loop;
  // it keeps a stray hready_in from accepting while this slave is stalling.
  assign w_accept   = hsel & hready_in & htrans[1] & hready;
  assign w_misalign = ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_err      = ({1'b0, haddr} >= LIMIT) || (hsize > 3'd2) || w_misalign;

  // Wait cycles are spent in WAIT; the OKAY completion is always the
  // following IDLE cycle with a pending transfer.
  assign w_complete = r_pend && (r_state == IDLE);
  assign w_idx      = r_addr[IDX_W+1:2];

  always_comb begin
    w_strb = 4'b0000;
    case (r_size[1:0])
      2'd0:    w_strb = 4'b0001 << r_addr[1:0];
      2'd1:    w_strb = 4'b0011 << {r_addr[1], 1'b0};
      default: w_strb = 4'b1111;
    endcase
  end

  always_comb begin
    w_next = r_state;
    hready = 1'b1;
    hresp  = 1'b0;
    case (r_state)
      IDLE, ERR2: begin
        hresp  = (r_state == ERR2);
        w_next = IDLE;
        if (w_accept) begin
          if (w_err)                 w_next = ERR1;
          else if (WAIT_STATES > 0)  w_next = WAIT;
        end
      end
      WAIT: begin
        hready = 1'b0;
        if (r_cnt == LAST_WAIT) w_next = IDLE;
      end
      ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
        w_next = ERR2;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_size  <= 3'd0;
      r_write <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((r_state == WAIT) && (w_next == WAIT)) ? r_cnt + 4'd1 : 4'd0;
      if (w_accept) begin
        r_addr  <= haddr;
        r_size  <= hsize;
        r_write <= hwrite;
        r_pend  <= !w_err;
      end else if (w_complete) begin
        r_pend  <= 1'b0;
      end
    end
  end

  // Write commits at the end of the completing cycle, so a read accepted at
  // that same edge sees the new word in its own data phase.
  always_ff @(posedge hclk) begin
    if (w_complete && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata   = (w_complete && !r_write) ? r_mem[w_idx] : '0;
  assign w_unused = ^{hburst, r_addr, r_size[2]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - directed scoreboard bench for ahb_mem_slave (0 and 3 wait states)
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3, hresp0, hresp3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          err;
    logic [31:0] rd;
    bit          chk_rd;
    int          waits;
  } exp_t;
  exp_t sb[$];

  always #5 hclk = ~hclk;

  ahb_mem_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hsize(hsize),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready0),
    .hburst(hburst), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  ahb_mem_slave #(.WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .hsize(hsize),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready3),
    .hburst(hburst), .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
  );

  function automatic logic f_rdy(input bit d3);
    return d3 ? hready3 : hready0;
  endfunction

  function automatic logic f_resp(input bit d3);
    return d3 ? hresp3 : hresp0;
  endfunction

  function automatic logic [31:0] f_rdata(input bit d3);
    return d3 ? hrdata3 : hrdata0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit err, input bit wr, input logic [31:0] rd, input int waits);
    exp_t e;
    e.err = err; e.rd = rd; e.chk_rd = !wr && !err; e.waits = waits;
    return e;
  endfunction

  // One non-pipelined transfer: address phase, then data phase until hready.
  task automatic xfer(input string tag, input bit d3, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input bit err,
                      input logic [31:0] rd, input int waits);
    exp_t e;
    int   n;
    bit   done;
    logic first_resp;
    sb.push_back(mk(err, wr, rd, waits));
    @(posedge hclk); #1;
    if (d3) hsel3 = 1'b1; else hsel0 = 1'b1;
    htrans = 2'd2; hwrite = wr; haddr = addr; hsize = size; hwdata = '0;
    @(posedge hclk); #1;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; hwdata = wdata;
    n = 0; done = 1'b0; first_resp = 1'bx;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge hclk);
      if (i == 0) first_resp = f_resp(d3);
      if (f_rdy(d3)) done = 1'b1;
      else n++;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_waits"}, 32'(n), 32'(e.waits));
    chk({tag, "_first_resp"}, 32'(first_resp), 32'(e.err));
    chk({tag, "_resp"}, 32'(f_resp(d3)), 32'(e.err));
    if (e.chk_rd) chk({tag, "_rdata"}, f_rdata(d3), e.rd);
    else          chk({tag, "_rdata_zero"}, f_rdata(d3), 32'h0);
  endtask

  initial begin
    exp_t e;
    hresetn = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; hsize = 3'd0;
    htrans = 2'd0; hwrite = 1'b0; hwdata = '0; hburst = 3'd0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hready0", 32'(hready0), 32'd1);
    chk("rst_hresp0", 32'(hresp0), 32'd0);
    chk("rst_hrdata0", hrdata0, 32'h0);
    chk("rst_hready3", 32'(hready3), 32'd1);
    hresetn = 1'b1;

    xfer("w_dead", 0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0, 0);
    xfer("r_dead", 0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF, 0);

    xfer("w_1122", 0, 1, 32'h10, 3'd2, 32'h11223344, 0, 32'h0, 0);
    xfer("wb_aa", 0, 1, 32'h13, 3'd0, 32'hAA000000, 0, 32'h0, 0);
    xfer("r_aa", 0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA223344, 0);

    xfer("w_0", 0, 1, 32'h00, 3'd2, 32'h0BADF00D, 0, 32'h0, 0);
    xfer("e_range", 0, 0, 32'd1024, 3'd2, 32'h0, 1, 32'h0, 1);
    xfer("e_mis_h", 0, 1, 32'h01, 3'd1, 32'hFFFFFFFF, 1, 32'h0, 1);
    xfer("e_size3", 0, 1, 32'h10, 3'd3, 32'hFFFFFFFF, 1, 32'h0, 1);
    xfer("r_0_kept", 0, 0, 32'h00, 3'd2, 32'h0, 0, 32'h0BADF00D, 0);
    xfer("r_10_kept", 0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA223344, 0);

    // IDLE then BUSY with hsel high: never accepted, zero-wait OKAY
    @(posedge hclk); #1;
    hsel0 = 1'b1; htrans = 2'd0; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    @(posedge hclk); #1;
    htrans = 2'd1; hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    chk("idle_hready", 32'(hready0), 32'd1);
    chk("idle_hresp", 32'(hresp0), 32'd0);
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'd0;
    @(negedge hclk);
    chk("busy_hready", 32'(hready0), 32'd1);
    chk("busy_hresp", 32'(hresp0), 32'd0);
    xfer("r_after_idle", 0, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAA223344, 0);

    xfer("wh_5566", 0, 1, 32'h12, 3'd1, 32'h55660000, 0, 32'h0, 0);
    xfer("r_5566", 0, 0, 32'h10, 3'd2, 32'h0, 0, 32'h55663344, 0);

    // Back-to-back write then read of the same word, no bubble
    sb.push_back(mk(0, 1, 32'h0, 0));
    sb.push_back(mk(0, 0, 32'hCAFEF00D, 0));
    @(posedge hclk); #1;
    hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
    @(posedge hclk); #1;
    htrans = 2'd2; hwrite = 1'b0; haddr = 32'h40; hwdata = 32'hCAFEF00D;
    @(negedge hclk);
    e = sb.pop_front();
    chk("b2b_w_hready", 32'(hready0), 32'd1);
    chk("b2b_w_hresp", 32'(hresp0), 32'(e.err));
    @(posedge hclk); #1;
    hsel0 = 1'b0; htrans = 2'd0;
    @(negedge hclk);
    e = sb.pop_front();
    chk("b2b_r_hready", 32'(hready0), 32'd1);
    chk("b2b_r_rdata", hrdata0, e.rd);

    xfer("w3_1234", 1, 1, 32'h20, 3'd2, 32'h12345678, 0, 32'h0, 3);
    xfer("r3_1234", 1, 0, 32'h20, 3'd2, 32'h0, 0, 32'h12345678, 3);

    // Reset in the middle of a wait-stated write aborts it
    @(posedge hclk); #1;
    hsel3 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'h99999999;
    @(negedge hclk);
    chk("rstw_in_wait", 32'(hready3), 32'd0);
    hresetn = 1'b0;
    #1;
    chk("rstw_hready", 32'(hready3), 32'd1);
    chk("rstw_hresp", 32'(hresp3), 32'd0);
    chk("rstw_hrdata", hrdata3, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    xfer("r3_old", 1, 0, 32'h20, 3'd2, 32'h0, 0, 32'h12345678, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
